perreg_arb4: RTL

PERREG_ARB4 -- requirements
Module: perreg_arb4

---
 rtl/perreg_arb4.sv | 94 +++++++++
 1 files changed

// File: rtl/perreg_arb4.sv
// Four-requester round-robin arbiter feeding one shared data register.
// A register holding an unconsumed word can be drained and refilled in the same cycle.
module perreg_arb4 #(
    parameter int DW   = 16,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] d,
    output logic [3:0]      gnt,
    output logic [DW-1:0]   q,
    output logic            qv,
    input  logic            qrdy,
    output logic [1:0]      qsrc,
    output logic [CNTW-1:0] gcnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [DW-1:0]   q_reg;
    logic [1:0]      qsrc_reg;
    logic [1:0]      ptr_reg;
    logic [CNTW-1:0] gcnt_reg;

    logic [DW-1:0]   slice [4];
    logic            window;
    logic            grant_any;
    logic [1:0]      grant_idx;
    logic [1:0]      cand;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign slice[gi] = d[gi*DW +: DW];
        end
    endgenerate

    // Rotated priority search; reset forces the grant low even though the window reads open.
    always_comb begin
        gnt       = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        window    = (state_reg == EMPTY) || qrdy;
        if (rstn && window) begin
            for (int k = 0; k < 4; k++) begin
                cand = ptr_reg + 2'(k);
                if (!grant_any && req[cand]) begin
                    gnt[cand] = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (grant_any) state_next = FULL;
            FULL:  if (qrdy && !grant_any) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= EMPTY;
            q_reg     <= '0;
            qsrc_reg  <= '0;
            ptr_reg   <= '0;
            gcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_any) begin
                q_reg    <= slice[grant_idx];
                qsrc_reg <= grant_idx;
                ptr_reg  <= grant_idx + 2'd1;
                gcnt_reg <= gcnt_reg + CNTW'(1);
            end
        end
    end

    assign q    = q_reg;
    assign qv   = (state_reg == FULL);
    assign qsrc = qsrc_reg;
    assign gcnt = gcnt_reg;

endmodule
